// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - redirect, instruction-memory and decode signals of the fetch sequencer
interface fetch_ctrl_if;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;
  logic        if_misalign;

  // Sequencer side
  modport master (
    input  br_taken, br_target, imem_ack, imem_rdata, id_ready,
    output imem_req, imem_addr, if_valid, if_pc, if_inst, if_misalign
  );

  // Execute / memory / decode side
  modport slave (
    output br_taken, br_target, imem_ack, imem_rdata, id_ready,
    input  imem_req, imem_addr, if_valid, if_pc, if_inst, if_misalign
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer; optional misaligned-redirect trap via FETCH_ALIGN_CHK_EN
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_HOLD} state_t;

  state_t      r_state, w_state;
  logic [31:0] r_fetch_addr, w_fetch_addr;
  logic [31:0] r_next_pc, w_next_pc;
  logic [31:0] r_pc, w_pc;
  logic [31:0] r_inst, w_inst;
  logic        r_kill, w_kill;
  logic        r_misalign, w_misalign;
  logic [31:0] w_tgt;
  logic        w_tgt_bad;

`ifdef FETCH_ALIGN_CHK_EN
  assign w_tgt_bad = (bus.br_target[1:0] != 2'b00);
  assign w_tgt     = w_tgt_bad ? TRAP_VEC : bus.br_target;
`else
  // Low target bits are dropped, so the trap vector is never consulted.
  logic w_unused;
  assign w_unused  = ^{bus.br_target[1:0], TRAP_VEC};
  assign w_tgt_bad = 1'b0;
  assign w_tgt     = {bus.br_target[31:2], 2'b00};
`endif

  // Next-state and next-register values; kill marks an outstanding request from a stale path.
  always_comb begin
    w_state      = r_state;
    w_fetch_addr = r_fetch_addr;
    w_next_pc    = r_next_pc;
    w_pc         = r_pc;
    w_inst       = r_inst;
    w_kill       = r_kill;
    w_misalign   = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.br_taken) begin
          w_misalign = w_tgt_bad;
        end
        if (bus.imem_ack) begin
          if (r_kill || bus.br_taken) begin
            w_kill       = 1'b0;
            w_fetch_addr = bus.br_taken ? w_tgt : r_next_pc;
          end else begin
            w_inst    = bus.imem_rdata;
            w_pc      = r_fetch_addr;
            w_next_pc = r_fetch_addr + 32'd4;
            w_state   = ST_HOLD;
          end
        end else if (bus.br_taken) begin
          // Address must stay put until the pending ack, so park the target.
          w_next_pc = w_tgt;
          w_kill    = 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.br_taken) begin
          w_misalign   = w_tgt_bad;
          w_fetch_addr = w_tgt;
          w_state      = ST_FETCH;
        end else if (bus.id_ready) begin
          w_fetch_addr = r_next_pc;
          w_state      = ST_FETCH;
        end
      end
      default: begin
        w_state = ST_BOOT;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_BOOT;
      r_fetch_addr <= RESET_PC;
      r_next_pc    <= RESET_PC;
      r_pc         <= 32'h0;
      r_inst       <= 32'h0;
      r_kill       <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_fetch_addr <= w_fetch_addr;
      r_next_pc    <= w_next_pc;
      r_pc         <= w_pc;
      r_inst       <= w_inst;
      r_kill       <= w_kill;
      r_misalign   <= w_misalign;
    end
  end

  assign bus.imem_req    = (r_state == ST_FETCH);
  assign bus.imem_addr   = r_fetch_addr;
  assign bus.if_valid    = (r_state == ST_HOLD);
  assign bus.if_pc       = r_pc;
  assign bus.if_inst     = r_inst;
  assign bus.if_misalign = r_misalign;

endmodule
